// File: rtl/alu_op_sequencer.sv
// Multicycle issue/writeback sequencer driving a combinational ALU.
// Ports: clk/rst, INSTR handshake, ALU_A/B/S2_ALU_OP out, ALU_RESULT in,
//   DONE/RESULT/ZERO status, DBG_ADDR/DBG_DATA register peek.
module alu_op_sequencer #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  INSTR,
  input  logic         INSTR_VALID,
  output logic         INSTR_READY,
  output logic [n-1:0] ALU_A,
  output logic [n-1:0] ALU_B,
  output logic [2:0]   S2_ALU_OP,
  input  logic [n-1:0] ALU_RESULT,
  output logic         DONE,
  output logic [n-1:0] RESULT,
  output logic         ZERO,
  input  logic [2:0]   DBG_ADDR,
  output logic [n-1:0] DBG_DATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [n-1:0] rf_q [8];
  logic [n-1:0] a_q, b_q, res_q;
  logic [2:0]   op_q, rd_q;

  logic [2:0]   f_op, f_rd, f_rs1, f_rs2;
  logic         f_imm;
  logic [5:0]   f_iv;
  logic [n-1:0] rd_a, rd_b, opnd_b;
  logic         accept;

  assign f_op  = INSTR[15:13];
  assign f_rd  = INSTR[12:10];
  assign f_rs1 = INSTR[9:7];
  assign f_rs2 = INSTR[6:4];
  assign f_imm = INSTR[3];
  assign f_iv  = {INSTR[6:4], INSTR[2:0]};

  // R0 is hardwired to zero on every read port.
  assign rd_a = (f_rs1 == 3'd0) ? '0 : rf_q[f_rs1];
  assign rd_b = (f_rs2 == 3'd0) ? '0 : rf_q[f_rs2];
  assign opnd_b = f_imm ? {{(n-6){1'b0}}, f_iv} : rd_b;
  assign DBG_DATA = (DBG_ADDR == 3'd0) ? '0 : rf_q[DBG_ADDR];

  assign accept = (state_q == IDLE) && INSTR_VALID;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (INSTR_VALID) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/strobe outputs are forced low while reset is held so an
  // aborted WB never shows DONE and no accept is advertised during reset.
  always_comb begin
    INSTR_READY = 1'b0;
    DONE        = 1'b0;
    if (!rst) begin
      INSTR_READY = (state_q == IDLE);
      DONE        = (state_q == WB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (accept) begin
        a_q  <= rd_a;
        b_q  <= opnd_b;
        op_q <= f_op;
        rd_q <= f_rd;
      end
      if (state_q == EXEC) res_q <= ALU_RESULT;
      if (state_q == WB && rd_q != 3'd0) rf_q[rd_q] <= res_q;
    end
  end

  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign S2_ALU_OP = op_q;
  assign RESULT    = res_q;
  assign ZERO      = (res_q == '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached.
// Ports: drives clk/rst/INSTR/ALU_RESULT/DBG_ADDR, checks all outputs.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] ALU_A, ALU_B, ALU_RESULT, RESULT, DBG_DATA;
  logic [2:0]  S2_ALU_OP, DBG_ADDR;
  logic        DONE, ZERO;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.n(32)) dut (
    .clk(clk), .rst(rst),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .S2_ALU_OP(S2_ALU_OP),
    .ALU_RESULT(ALU_RESULT), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always_comb begin
    ALU_RESULT = '0;
    case (S2_ALU_OP)
      3'd0: ALU_RESULT = ALU_A;
      3'd1: ALU_RESULT = ~ALU_A;
      3'd2: ALU_RESULT = ALU_A & ALU_B;
      3'd3: ALU_RESULT = ALU_A + ALU_B;
      3'd4: ALU_RESULT = ~(ALU_A | ALU_B);
      3'd5: ALU_RESULT = ~(ALU_A & ALU_B);
      3'd6: ALU_RESULT = ALU_A - ALU_B;
      3'd7: ALU_RESULT = {31'd0, ALU_A < ALU_B};
      default: ALU_RESULT = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, rd, rs1, rs2,
                                      input logic imm, input logic [5:0] iv);
    return {op, rd, rs1, imm ? iv[5:3] : rs2, imm, iv[2:0]};
  endfunction

  // Issue one instruction; returns at the negedge of the DONE cycle.
  task automatic exec(input logic [2:0] op, rd, rs1, rs2,
                      input logic imm, input logic [5:0] iv,
                      input bit chk, input logic [31:0] exp);
    @(negedge clk);
    check("ready_idle", 32'(INSTR_READY), 32'd1);
    INSTR = enc(op, rd, rs1, rs2, imm, iv);
    INSTR_VALID = 1'b1;
    @(negedge clk);
    INSTR_VALID = 1'b0;
    if (chk) begin
      check("op_exec", 32'(S2_ALU_OP), 32'(op));
      check("done_exec", 32'(DONE), 32'd0);
      check("ready_exec", 32'(INSTR_READY), 32'd0);
    end
    @(negedge clk);
    check("done_wb", 32'(DONE), 32'd1);
    if (chk) begin
      check("result", RESULT, exp);
      check("op_wb", 32'(S2_ALU_OP), 32'(op));
    end
  endtask

  task automatic dbg(input logic [2:0] addr, input logic [31:0] exp);
    @(negedge clk);
    DBG_ADDR = addr;
    #1;
    check("dbg_data", DBG_DATA, exp);
  endtask

  // Builds a 32-bit constant with immediate adds and self-doubling.
  task automatic load(input logic [2:0] rd, input logic [31:0] v);
    exec(3'd3, rd, 3'd0, 3'd0, 1'b1, {4'd0, v[31:30]}, 1'b0, 32'd0);
    for (int c = 4; c >= 0; c--) begin
      for (int s = 0; s < 6; s++)
        exec(3'd3, rd, rd, rd, 1'b0, 6'd0, 1'b0, 32'd0);
      exec(3'd3, rd, rd, 3'd0, 1'b1, v[c*6 +: 6], 1'b0, 32'd0);
    end
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'hF0F0F0F0;
    sweep_exp[1] = 32'h0F0F0F0F;
    sweep_exp[2] = 32'h00F000F0;
    sweep_exp[3] = 32'h00E100E0;
    sweep_exp[4] = 32'h000F000F;
    sweep_exp[5] = 32'hFF0FFF0F;
    sweep_exp[6] = 32'hE100E100;
    sweep_exp[7] = 32'h00000000;

    rst = 1'b1;
    INSTR = '0;
    INSTR_VALID = 1'b1;
    DBG_ADDR = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(INSTR_READY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_a", ALU_A, 32'd0);
    check("rst_b", ALU_B, 32'd0);
    check("rst_op", 32'(S2_ALU_OP), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_zero", 32'(ZERO), 32'd1);
    rst = 1'b0;
    INSTR_VALID = 1'b0;

    exec(3'd3, 3'd1, 3'd0, 3'd0, 1'b1, 6'd5, 1'b1, 32'd5);
    exec(3'd3, 3'd2, 3'd1, 3'd0, 1'b1, 6'd7, 1'b1, 32'd12);
    check("zero_12", 32'(ZERO), 32'd0);
    dbg(3'd2, 32'd12);
    exec(3'd6, 3'd3, 3'd1, 3'd2, 1'b0, 6'd0, 1'b1, 32'hFFFFFFF9);
    check("sub_a", ALU_A, 32'd5);
    check("sub_b", ALU_B, 32'd12);
    exec(3'd7, 3'd4, 3'd1, 3'd2, 1'b0, 6'd0, 1'b1, 32'd1);
    exec(3'd7, 3'd4, 3'd2, 3'd1, 1'b0, 6'd0, 1'b1, 32'd0);
    check("zero_slt", 32'(ZERO), 32'd1);
    dbg(3'd3, 32'hFFFFFFF9);
    exec(3'd3, 3'd0, 3'd0, 3'd0, 1'b1, 6'd63, 1'b1, 32'd63);
    dbg(3'd0, 32'd0);

    // Continuous valid: ADD R1=R1+1 accepted once per three cycles.
    @(negedge clk);
    INSTR = enc(3'd3, 3'd1, 3'd1, 3'd0, 1'b1, 6'd1);
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("hold_ready", 32'(INSTR_READY), (i % 3 == 0) ? 32'd1 : 32'd0);
      check("hold_done", 32'(DONE), (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i < 8) @(negedge clk);
    end
    @(negedge clk);
    INSTR_VALID = 1'b0;
    DBG_ADDR = 3'd1;
    #1;
    check("hold_r1", DBG_DATA, 32'd8);

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    INSTR = enc(3'd3, 3'd5, 3'd0, 3'd0, 1'b1, 6'd9);
    INSTR_VALID = 1'b1;
    @(negedge clk);
    INSTR_VALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_ready", 32'(INSTR_READY), 32'd0);
    check("abort_a", ALU_A, 32'd0);
    check("abort_b", ALU_B, 32'd0);
    check("abort_op", 32'(S2_ALU_OP), 32'd0);
    check("abort_result", RESULT, 32'd0);
    check("abort_zero", 32'(ZERO), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_rel", 32'(INSTR_READY), 32'd1);
    check("abort_done_rel", 32'(DONE), 32'd0);
    DBG_ADDR = 3'd5;
    #1;
    check("abort_r5", DBG_DATA, 32'd0);
    DBG_ADDR = 3'd1;
    #1;
    check("abort_r1", DBG_DATA, 32'd0);

    load(3'd6, 32'hF0F0F0F0);
    load(3'd7, 32'h0FF00FF0);
    dbg(3'd6, 32'hF0F0F0F0);
    dbg(3'd7, 32'h0FF00FF0);
    for (int op = 0; op < 8; op++) begin
      exec(3'(op), 3'd3, 3'd6, 3'd7, 1'b0, 6'd0, 1'b1, sweep_exp[op]);
      check("sweep_a", ALU_A, 32'hF0F0F0F0);
      check("sweep_b", ALU_B, 32'h0FF00FF0);
    end
    dbg(3'd3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
